// File: rtl/mp_ctrl_pkg.sv
// Shared definitions for the multiplier-project controller and the operand latch block.
// The state codes are a fixed contract: the operand latch block decodes them.
package mp_ctrl_pkg;

  localparam int unsigned STATE_W   = 4;
  localparam int unsigned OP_EN     = 0;
  localparam int unsigned OP_SIGNED = 1;

  typedef enum logic [STATE_W-1:0] {
    StInit    = 4'd0,
    StOpRead  = 4'd1,
    StOpWait1 = 4'd2,
    StRaRead  = 4'd3,
    StRbRead  = 4'd4,
    StOpWait2 = 4'd5,
    StOpCal   = 4'd6,
    StSelect  = 4'd7,
    StOpWait3 = 4'd8,
    StResult  = 4'd9
  } state_e;

endpackage

// File: rtl/mp_ctrl_wdog.sv
// OP_CAL cycle counter: zero on the entry cycle, saturates at Timeout-1 and flags expiry there.
module mp_ctrl_wdog #(
  parameter int unsigned Timeout = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic zero_o,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(Timeout);
  localparam logic [CntW-1:0] CntMax = CntW'(Timeout - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o   = (cnt_q == '0);
  assign expire_o = (cnt_q == CntMax);

endmodule

// File: rtl/mp_ctrl.sv
// Sequencing FSM: fetch op/Ra/Rb over the shared bus, run the multiplier under a watchdog,
// write the 64-bit product back and raise an interrupt.
module mp_ctrl
  import mp_ctrl_pkg::*;
#(
  parameter logic [7:0]  OP_ADDR  = 8'h00,
  parameter logic [7:0]  RA_ADDR  = 8'h01,
  parameter logic [7:0]  RB_ADDR  = 8'h02,
  parameter logic [7:0]  RES_ADDR = 8'h03,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               opstart,
  input  logic               m_grant,
  input  logic [63:0]        m_din,
  output logic               m_req,
  output logic               m_wr,
  output logic [7:0]         m_addr,
  output logic [63:0]        m_dout,
  output logic [STATE_W-1:0] cur_state,
  output logic               mul_start,
  output logic               mul_signed,
  input  logic               mul_done,
  input  logic [63:0]        mul_result,
  output logic               busy,
  output logic               interrupt,
  output logic               err
);

  state_e      state_d, state_q;
  logic [63:0] result_d, result_q;
  logic [63:0] m_dout_d, m_dout_q;
  logic        op_signed_d, op_signed_q;
  logic        mul_signed_d, mul_signed_q;
  logic        err_d, err_q;
  logic        wd_zero, wd_expire;

  // Only the op control bits are needed here; Ra/Rb are captured by the operand latch block.
  logic unused_din;
  assign unused_din = ^m_din;

  mp_ctrl_wdog #(
    .Timeout (TIMEOUT)
  ) u_wdog (
    .clk_i    (clk),
    .rst_i    (reset),
    .clr_i    (state_q != StOpCal),
    .en_i     (state_q == StOpCal),
    .zero_o   (wd_zero),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d      = state_q;
    result_d     = result_q;
    op_signed_d  = op_signed_q;
    err_d        = err_q;
    case (state_q)
      StInit: begin
        if (opstart) begin
          state_d  = StOpRead;
          err_d    = 1'b0;
          result_d = '0;
        end
      end
      StOpRead:  if (m_grant) state_d = StOpWait1;
      StOpWait1: begin
        op_signed_d = m_din[OP_SIGNED];
        if (!m_din[OP_EN]) begin
          state_d  = StResult;
          result_d = '0;
        end else begin
          state_d = StRaRead;
        end
      end
      StRaRead:  if (m_grant) state_d = StRbRead;
      StRbRead:  if (m_grant) state_d = StOpWait2;
      StOpWait2: state_d = StOpCal;
      StOpCal: begin
        // A completion in the expiry cycle takes priority over the abort.
        if (mul_done) begin
          result_d = mul_result;
          state_d  = StSelect;
        end else if (wd_expire) begin
          result_d = '1;
          err_d    = 1'b1;
          state_d  = StSelect;
        end
      end
      StSelect:  if (m_grant) state_d = StOpWait3;
      StOpWait3: state_d = StResult;
      StResult:  if (!opstart) state_d = StInit;
      default:   state_d = StInit;
    endcase

    mul_signed_d = mul_signed_q;
    if (state_q == StOpWait2) begin
      mul_signed_d = op_signed_q;
    end
    if (state_d == StInit) begin
      mul_signed_d = 1'b0;
    end

    m_dout_d = (state_d == StSelect) ? result_d : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StInit;
      result_q     <= '0;
      m_dout_q     <= '0;
      op_signed_q  <= 1'b0;
      mul_signed_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      result_q     <= result_d;
      m_dout_q     <= m_dout_d;
      op_signed_q  <= op_signed_d;
      mul_signed_q <= mul_signed_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    m_req  = 1'b0;
    m_wr   = 1'b0;
    m_addr = '0;
    case (state_q)
      StOpRead, StOpWait1: begin
        m_req  = 1'b1;
        m_addr = OP_ADDR;
      end
      StRaRead: begin
        m_req  = 1'b1;
        m_addr = RA_ADDR;
      end
      StRbRead: begin
        m_req  = 1'b1;
        m_addr = RB_ADDR;
      end
      StSelect: begin
        m_req  = 1'b1;
        m_wr   = 1'b1;
        m_addr = RES_ADDR;
      end
      default: ;
    endcase
  end

  assign cur_state  = state_q;
  assign mul_start  = (state_q == StOpCal) && wd_zero;
  assign mul_signed = mul_signed_q;
  assign m_dout     = m_dout_q;
  assign busy       = (state_q != StInit);
  assign interrupt  = (state_q == StResult);
  assign err        = err_q;

endmodule

// File: tb/tb_mp_ctrl.sv
// Directed bench for mp_ctrl with a simple bus memory model; watchdog shortened to 8 cycles.
module tb_mp_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        opstart;
  logic        m_grant;
  logic [63:0] m_din = '0;
  logic        m_req, m_wr;
  logic [7:0]  m_addr;
  logic [63:0] m_dout;
  logic [3:0]  cur_state;
  logic        mul_start, mul_signed;
  logic        mul_done;
  logic [63:0] mul_result;
  logic        busy, interrupt, err;

  logic [63:0] mem [256];
  int          wr_cnt = 0;
  int          rd_ra = 0;
  int          rd_rb = 0;
  logic [7:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;

  int n_total = 0;
  int n_bad   = 0;

  mp_ctrl #(
    .TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .opstart    (opstart),
    .m_grant    (m_grant),
    .m_din      (m_din),
    .m_req      (m_req),
    .m_wr       (m_wr),
    .m_addr     (m_addr),
    .m_dout     (m_dout),
    .cur_state  (cur_state),
    .mul_start  (mul_start),
    .mul_signed (mul_signed),
    .mul_done   (mul_done),
    .mul_result (mul_result),
    .busy       (busy),
    .interrupt  (interrupt),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Bus memory: read data appears the cycle after a granted read address.
  always @(posedge clk) begin
    if (m_req && m_grant && !m_wr) begin
      m_din <= mem[m_addr];
      if (m_addr == 8'h01) rd_ra <= rd_ra + 1;
      if (m_addr == 8'h02) rd_rb <= rd_rb + 1;
    end
    if (m_req && m_grant && m_wr) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= m_addr;
      wr_data <= m_dout;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    opstart = 1'b1;
    step();
    opstart = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [3:0] st, input int budget);
    for (int i = 0; i < budget && cur_state != st; i++) step();
    check(tag, 64'(cur_state), 64'(st));
  endtask

  task automatic load_mem(input logic [63:0] op, input logic [63:0] ra, input logic [63:0] rb);
    mem[0] = op;
    mem[1] = ra;
    mem[2] = rb;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int wr_base, ra_base, rb_base;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    reset = 1'b1; opstart = 1'b0; m_grant = 1'b1; mul_done = 1'b0; mul_result = '0;
    step(); step();
    check("rst_state", 64'(cur_state), 64'd0);
    check("rst_outs", 64'({m_req, m_wr, mul_start, mul_signed, busy, interrupt, err}), 64'd0);
    check("rst_bus", 64'({m_addr, m_dout}), 64'd0);
    reset = 1'b0;
    step();

    // Normal multiply, zero-wait grant: mul_start at cycle 6, interrupt at cycle 13.
    load_mem(64'h0001, 64'd3, 64'd5);
    wr_base = wr_cnt;
    pulse_start();
    check("n_busy", 64'(busy), 64'd1);
    repeat (5) step();
    check("n_cal_state", 64'(cur_state), 64'd6);
    check("n_mul_start", 64'(mul_start), 64'd1);
    check("n_unsigned", 64'(mul_signed), 64'd0);
    step();
    check("n_start_pulse", 64'(mul_start), 64'd0);
    repeat (3) step();
    mul_done = 1'b1; mul_result = 64'd15;
    step();
    mul_done = 1'b0;
    check("n_select", 64'({cur_state, m_req, m_wr, m_addr}), 64'({4'd7, 1'b1, 1'b1, 8'h03}));
    check("n_dout", m_dout, 64'd15);
    step(); step();
    check("n_irq_c13", 64'({cur_state, interrupt}), 64'({4'd9, 1'b1}));
    check("n_wr", 64'(wr_cnt - wr_base), 64'd1);
    check("n_wr_addr", 64'(wr_addr), 64'd3);
    check("n_wr_data", wr_data, 64'd15);
    check("n_err", 64'(err), 64'd0);
    step();
    check("n_idle", 64'({cur_state, busy}), 64'd0);

    // Signed multiply: mul_signed rises on OP_CAL entry and holds until INIT.
    load_mem(64'h0003, 64'hFFFF_FFFE, 64'd3);
    pulse_start();
    repeat (4) step();
    check("s_wait2_unsigned", 64'(mul_signed), 64'd0);
    step();
    check("s_cal_signed", 64'({cur_state, mul_signed}), 64'({4'd6, 1'b1}));
    step(); step();
    mul_done = 1'b1; mul_result = 64'hFFFF_FFFF_FFFF_FFFA;
    step();
    mul_done = 1'b0;
    check("s_select_signed", 64'(mul_signed), 64'd1);
    wait_state("s_result", 4'd9, 10);
    check("s_wr_data", wr_data, 64'hFFFF_FFFF_FFFF_FFFA);
    step();
    check("s_init_signed", 64'({cur_state, mul_signed}), 64'd0);

    // Nop: interrupt 3 cycles after opstart, no operand reads, no write.
    load_mem(64'h0000, 64'd7, 64'd7);
    wr_base = wr_cnt; ra_base = rd_ra; rb_base = rd_rb;
    pulse_start();
    step(); step();
    check("nop_irq_c3", 64'({cur_state, interrupt}), 64'({4'd9, 1'b1}));
    check("nop_no_rd", 64'((rd_ra - ra_base) + (rd_rb - rb_base)), 64'd0);
    step();
    check("nop_no_wr", 64'(wr_cnt - wr_base), 64'd0);

    // Grant stalls of 5 cycles in RA_READ, RB_READ and SELECT.
    load_mem(64'h0001, 64'd7, 64'd9);
    wr_base = wr_cnt; ra_base = rd_ra; rb_base = rd_rb;
    pulse_start();
    wait_state("g_ra", 4'd3, 10);
    m_grant = 1'b0;
    repeat (5) step();
    check("g_ra_hold", 64'({cur_state, m_req}), 64'({4'd3, 1'b1}));
    m_grant = 1'b1;
    step();
    m_grant = 1'b0;
    repeat (5) step();
    check("g_rb_hold", 64'(cur_state), 64'd4);
    m_grant = 1'b1;
    step();
    check("g_wait2", 64'({cur_state, m_req}), 64'({4'd5, 1'b0}));
    check("g_rd_once", 64'({8'(rd_ra - ra_base), 8'(rd_rb - rb_base)}), 64'h0101);
    wait_state("g_cal", 4'd6, 5);
    mul_done = 1'b1; mul_result = 64'd63; m_grant = 1'b0;
    step();
    mul_done = 1'b0;
    repeat (5) step();
    check("g_sel_hold", 64'({cur_state, m_req}), 64'({4'd7, 1'b1}));
    check("g_sel_no_wr", 64'(wr_cnt - wr_base), 64'd0);
    m_grant = 1'b1;
    step();
    check("g_wait3", 64'({cur_state, m_req}), 64'({4'd8, 1'b0}));
    check("g_wr_data", wr_data, 64'd63);
    wait_state("g_idle", 4'd0, 5);

    // Timeout with TIMEOUT=8: OP_CAL lasts exactly 8 cycles, then all-ones write and err.
    load_mem(64'h0001, 64'd2, 64'd2);
    pulse_start();
    wait_state("t_cal", 4'd6, 10);
    repeat (7) step();
    check("t_last_cal", 64'({cur_state, err}), 64'({4'd6, 1'b0}));
    step();
    check("t_abort", 64'({cur_state, err}), 64'({4'd7, 1'b1}));
    check("t_dout", m_dout, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_state("t_result", 4'd9, 5);
    check("t_wr_data", wr_data, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_state("t_idle", 4'd0, 5);
    check("t_err_sticky", 64'(err), 64'd1);

    // Next opstart clears err; mul_done in the expiry cycle wins over the abort.
    pulse_start();
    check("t_err_clr", 64'(err), 64'd0);
    wait_state("b_cal", 4'd6, 10);
    repeat (7) step();
    mul_done = 1'b1; mul_result = 64'h1234;
    step();
    mul_done = 1'b0;
    check("b_done_wins", 64'({cur_state, err}), 64'({4'd7, 1'b0}));
    check("b_dout", m_dout, 64'h1234);
    wait_state("b_idle", 4'd0, 10);

    // Reset in OP_CAL (signed op so mul_signed is high before reset).
    load_mem(64'h0003, 64'd4, 64'd4);
    pulse_start();
    wait_state("r1_cal", 4'd6, 10);
    step();
    check("r1_pre_signed", 64'(mul_signed), 64'd1);
    reset = 1'b1;
    #1;
    check("r1_state", 64'(cur_state), 64'd0);
    check("r1_outs", 64'({m_req, m_wr, mul_start, mul_signed, busy, interrupt}), 64'd0);
    step();
    reset = 1'b0;
    step();

    // Reset while stalled in SELECT: the pending write must never happen.
    load_mem(64'h0001, 64'd3, 64'd5);
    pulse_start();
    wait_state("r2_cal", 4'd6, 10);
    mul_done = 1'b1; mul_result = 64'd15; m_grant = 1'b0;
    step();
    mul_done = 1'b0;
    check("r2_select", 64'(cur_state), 64'd7);
    wr_base = wr_cnt;
    reset = 1'b1;
    #1;
    check("r2_state", 64'(cur_state), 64'd0);
    check("r2_bus", 64'({m_req, m_wr, m_addr, busy}), 64'd0);
    check("r2_dout", m_dout, 64'd0);
    m_grant = 1'b1;
    step();
    reset = 1'b0;
    step(); step();
    check("r2_no_wr", 64'(wr_cnt - wr_base), 64'd0);

    // Normal run after reset.
    pulse_start();
    wait_state("r3_cal", 4'd6, 10);
    mul_done = 1'b1; mul_result = 64'd15;
    step();
    mul_done = 1'b0;
    wait_state("r3_result", 4'd9, 5);
    check("r3_wr", 64'({wr_addr, 8'(wr_cnt - wr_base)}), 64'h0301);
    check("r3_wr_data", wr_data, 64'd15);
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mp_ctrl.md
# mp_ctrl

Sequencing controller for the multiplier project datapath. On a start pulse it acquires the shared bus and fetches the op word, Ra and Rb from bus memory. It then launches the multiplier, waits for completion (with a watchdog), writes the 64-bit product back and raises an interrupt. It is the FSM that drives the operand latch block, and it owns the 4-bit state encoding that block decodes.

## Interface
- OP_ADDR, 8'h00, bus address of op word (low 16 bits used)
- RA_ADDR, 8'h01, bus address of Ra (low 32 bits used)
- RB_ADDR, 8'h02, bus address of Rb (low 32 bits used)
- RES_ADDR, 8'h03, bus address written with 64-bit result
- TIMEOUT, 64, max OP_CAL cycles before abort (≥2)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- opstart  in  1  start request, sampled only in INIT
- m_grant  in  1  bus granted to this master
- m_din  in  64  bus read data (valid the cycle after the read address)
- m_req  out  1  bus request
- m_wr  out  1  1 = write, 0 = read
- m_addr  out  8  bus address
- m_dout  out  64  bus write data
- cur_state  out  4  current state, consumed by the operand latch block
- mul_start  out  1  one-cycle multiplier launch
- mul_signed  out  1  op[1], held from OP_CAL entry until INIT
- mul_done  in  1  multiplier result valid
- mul_result  in  64  multiplier product
- busy  out  1  high in every state except INIT
- interrupt  out  1  high in RESULT
- err  out  1  sticky timeout flag, cleared on next accepted opstart

## Operation
- States and codes (shared, fixed): INIT 0, OP_READ 1, OP_WAIT1 2, RA_READ 3, RB_READ 4, OP_WAIT2 5, OP_CAL 6, SELECT 7, OP_WAIT3 8, RESULT 9. Codes 10–15 go to INIT.
- INIT: if opstart=1, go to OP_READ and clear err. Otherwise stay.
- OP_READ: assert m_req, m_addr=OP_ADDR, m_wr=0. On m_grant go to OP_WAIT1, else stall.
- OP_WAIT1: latch op=m_din[15:0]. m_req stays high.
  - If op[0]=0 (nop), go to RESULT with result=0.
  - Otherwise go to RA_READ.
- RA_READ: read RA_ADDR. On m_grant go to RB_READ, else stall.
- RB_READ: latch Ra=m_din[31:0]; read RB_ADDR. On m_grant go to OP_WAIT2. If no grant, stall with Ra already latched; do not re-latch.
- OP_WAIT2: latch Rb=m_din[31:0]; drop m_req; go to OP_CAL.
- OP_CAL:
  - Pulse mul_start in the first cycle only.
  - Count cycles; on mul_done latch result=mul_result and go to SELECT.
  - If the count reaches TIMEOUT without mul_done, set err, result=64'hFFFF_FFFF_FFFF_FFFF, and go to SELECT.
  - If mul_done and timeout occur in the same cycle, mul_done wins.
- SELECT: assert m_req, m_wr=1, m_addr=RES_ADDR, m_dout=result. On m_grant go to OP_WAIT3, else stall.
- OP_WAIT3: drop m_req; go to RESULT.
- RESULT: interrupt=1. Wait for opstart=0, then go to INIT. A held-high opstart must not re-trigger.
- Nop path: skips the bus write; RESULT with interrupt and no memory update.

## Timing
- Reset values: state INIT, all outputs 0, op/Ra/Rb/result/counter 0.
- Reset mid-operation returns to INIT immediately (asynchronously). No partial write completes after reset deasserts.
- Outputs are Moore (decoded from the registered state). m_dout and mul_signed are registered.
- Bus reads: address in cycle N, data sampled in cycle N+1.
- Latency, zero-wait grant: opstart to mul_start = 6 cycles. mul_done to interrupt = 3 cycles. Total = 9 + multiplier latency.
- Watchdog: the counter is 0 in the OP_CAL entry cycle. Abort happens at count == TIMEOUT-1.

## Structure
- The shared package holds the state code constants (INIT..RESULT), the 4-bit state width and the op bit positions (OP_EN=0, OP_SIGNED=1). The operand latch block uses the same package.
- One natural sub-module: mp_ctrl_wdog, the OP_CAL cycle counter with clear/enable/expire.
- The op/Ra/Rb latching stays in the existing operand latch block, driven by cur_state. This block keeps local copies only for m_dout and mul_signed.

## Test plan
- Normal multiply: op=16'h0001, Ra=3, Rb=5, mul_done 4 cycles after mul_start with result 15 → write 64'd15 to addr 3; interrupt at cycle 13; err=0.
- Signed multiply: op=16'h0003, Ra=32'hFFFF_FFFE, Rb=3 → mul_signed=1 through OP_CAL; written result equals mul_result.
- Nop: op=16'h0000 → no RA/RB reads, no write to addr 3; interrupt 3 cycles after opstart.
- Grant stalls: withhold m_grant 5 cycles in each of RA_READ, RB_READ and SELECT → state holds; Ra/Rb captured exactly once; final write is correct.
- Timeout: TIMEOUT=8 with mul_done never asserted → err=1; write 64'hFFFF_FFFF_FFFF_FFFF; next opstart clears err.
- Reset in OP_CAL and in SELECT: assert reset → state INIT and all outputs 0 in the same cycle; a subsequent normal run produces correct results.
